// File: rtl/calc_sequencer_if.sv
// Signal bundle between the command host, the sequencer and the calculator.
// The host/bench side uses master; the sequencer uses slave.
interface calc_sequencer_if #(
  parameter int CNT_W = 8
);
  logic [23:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic             WEN;
  logic [2:0]       RW;
  logic [2:0]       RX;
  logic [2:0]       RY;
  logic [7:0]       DataIn;
  logic             Sel;
  logic [3:0]       Ctrl;
  logic [7:0]       busY;
  logic             Carry;
  logic [7:0]       res_data;
  logic             res_carry;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] ins_count;

  modport master (
    output in_data, in_valid, res_ready, busY, Carry,
    input  in_ready, WEN, RW, RX, RY, DataIn, Sel, Ctrl,
           res_data, res_carry, res_valid, ins_count
  );

  modport slave (
    input  in_data, in_valid, res_ready, busY, Carry,
    output in_ready, WEN, RW, RX, RY, DataIn, Sel, Ctrl,
           res_data, res_carry, res_valid, ins_count
  );
endinterface

// File: rtl/calc_sequencer.sv
// Buffers 24-bit instruction words in a FIFO and issues each one to the
// calculator for a single cycle, optionally returning busY/Carry.
module calc_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  calc_sequencer_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  logic [23:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full, empty, push, pop;
  logic [23:0]      head;

  state_e           state_q;
  logic             wen_q, sel_q, rd_q;
  logic [2:0]       rw_q, rx_q, ry_q;
  logic [7:0]       imm_q;
  logic [3:0]       ctrl_q;
  logic [7:0]       res_data_q;
  logic             res_carry_q, res_valid_q;
  logic [CNT_W-1:0] cnt_q;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // Full refuses a push even when a pop happens in the same cycle.
  assign push  = bus.in_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.in_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Calculator fields are loaded on pop and cleared on leaving ISSUE, so the
  // ports are plain flop outputs that are nonzero only during ISSUE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      {ctrl_q, sel_q, wen_q, rd_q, rw_q, rx_q, ry_q, imm_q} <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            {ctrl_q, sel_q, wen_q, rd_q, rw_q, rx_q, ry_q, imm_q} <= head;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          {ctrl_q, sel_q, wen_q, rd_q, rw_q, rx_q, ry_q, imm_q} <= '0;
          if (rd_q) begin
            res_data_q  <= bus.busY;
            res_carry_q <= bus.Carry;
            res_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q <= IDLE;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.WEN       = wen_q;
  assign bus.RW        = rw_q;
  assign bus.RX        = rx_q;
  assign bus.RY        = ry_q;
  assign bus.DataIn    = imm_q;
  assign bus.Sel       = sel_q;
  assign bus.Ctrl      = ctrl_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_valid = res_valid_q;
  assign bus.ins_count = cnt_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small register-file model of the
// calculator supplying busY/Carry.
module tb_calc_sequencer;
  logic Clk;
  logic Rst;
  logic init_regs;
  logic [7:0] regs [8];

  calc_sequencer_if #(.CNT_W(8)) bus ();

  calc_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Calculator stand-in: not reset by Rst, writes DataIn on WEN.
  assign bus.busY  = regs[bus.RY];
  assign bus.Carry = (bus.RY == 3'd2);
  always @(posedge Clk) begin
    if (init_regs) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      regs[2] <= 8'h3C;
      regs[3] <= 8'h11;
    end else if (bus.WEN) begin
      regs[bus.RW] <= bus.DataIn;
    end
  end

  typedef struct {
    logic [23:0] word;
    logic        wen;
    logic [2:0]  rw;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [7:0]  imm;
    logic        sel;
    logic [3:0]  ctrl;
    logic        rd;
    logic [7:0]  res;
    logic        carry;
  } vec_t;

  vec_t vecs [5];
  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;
  logic [23:0] fwords [6];
  logic [7:0]  forder [6];
  logic [7:0]  seen [$];
  int idx;
  int issued;
  bit acc;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin
    //          word      wen  rw    rx    ry    imm    sel  ctrl rd   res    carry
    vecs[0] = '{24'h244005, 1'b1, 3'd1, 3'd0, 3'd0, 8'h05, 1'b0, 4'h2, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{24'h0A0200, 1'b0, 3'd0, 3'd0, 3'd2, 8'h00, 1'b1, 4'h0, 1'b1, 8'h3C, 1'b1};
    vecs[2] = '{24'h06C377, 1'b1, 3'd3, 3'd0, 3'd3, 8'h77, 1'b0, 4'h0, 1'b1, 8'h11, 1'b0};
    vecs[3] = '{24'hFDEEA5, 1'b1, 3'd7, 3'd5, 3'd6, 8'hA5, 1'b1, 4'hF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{24'h921700, 1'b0, 3'd0, 3'd2, 3'd7, 8'h00, 1'b0, 4'h9, 1'b1, 8'hA5, 1'b0};

    fwords[0] = 24'h020010; forder[0] = 8'h10;
    for (int i = 1; i < 6; i++) begin
      fwords[i] = 24'(i);
      forder[i] = 8'(i);
    end

    // Reset held two cycles with an instruction offered.
    Rst = 1'b1;
    init_regs = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 24'h244005;
    bus.res_ready = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    init_regs = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_wen", bus.WEN, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_ins_count", bus.ins_count, 0);
    tick();
    tick();
    check("rst_no_push_count", bus.ins_count, 0);
    check("rst_no_push_wen", bus.WEN, 0);

    foreach (vecs[k]) begin
      bus.in_data = vecs[k].word;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      check($sformatf("v%0d_WEN", k), bus.WEN, vecs[k].wen);
      check($sformatf("v%0d_RW", k), bus.RW, vecs[k].rw);
      check($sformatf("v%0d_RX", k), bus.RX, vecs[k].rx);
      check($sformatf("v%0d_RY", k), bus.RY, vecs[k].ry);
      check($sformatf("v%0d_DataIn", k), bus.DataIn, vecs[k].imm);
      check($sformatf("v%0d_Sel", k), bus.Sel, vecs[k].sel);
      check($sformatf("v%0d_Ctrl", k), bus.Ctrl, vecs[k].ctrl);
      tick();
      exp_cnt++;
      check($sformatf("v%0d_wen_one_cycle", k), bus.WEN, 0);
      check($sformatf("v%0d_datain_clear", k), bus.DataIn, 0);
      check($sformatf("v%0d_ins_count", k), bus.ins_count, exp_cnt);
      check($sformatf("v%0d_res_valid", k), bus.res_valid, vecs[k].rd);
      if (vecs[k].rd) begin
        for (int c = 0; c < 5; c++) begin
          check($sformatf("v%0d_hold%0d_valid", k, c), bus.res_valid, 1);
          check($sformatf("v%0d_hold%0d_data", k, c), bus.res_data, vecs[k].res);
          check($sformatf("v%0d_hold%0d_carry", k, c), bus.res_carry, vecs[k].carry);
          check($sformatf("v%0d_hold%0d_wen", k, c), bus.WEN, 0);
          tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check($sformatf("v%0d_res_clear", k), bus.res_valid, 0);
      end
    end

    // FIFO fill under backpressure: one rd instruction then DEPTH more.
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      bus.res_ready = (c >= 10);
      bus.in_valid = (idx < 6);
      if (idx < 6) bus.in_data = fwords[idx];
      if (c == 5) begin
        check("full_accepted", idx, 5);
        check("full_in_ready_low", bus.in_ready, 0);
      end
      if (c == 9) check("full_still_refused", bus.in_ready, 0);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
      if (bus.DataIn != 8'h00) seen.push_back(bus.DataIn);
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    exp_cnt += 6;
    check("full_all_accepted", idx, 6);
    check("full_issue_total", seen.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("full_order%0d", i), (i < seen.size()) ? seen[i] : 8'hFF, forder[i]);
    check("full_ins_count", bus.ins_count, exp_cnt);
    check("full_res_valid", bus.res_valid, 0);
    check("full_in_ready_back", bus.in_ready, 1);

    // Reset at the edge ending a writing ISSUE.
    bus.in_data = 24'h07045A;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("rwi_issue_wen", bus.WEN, 1);
    check("rwi_issue_rw", bus.RW, 4);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("rwi_res_valid", bus.res_valid, 0);
    check("rwi_wen", bus.WEN, 0);
    check("rwi_ins_count", bus.ins_count, 0);
    check("rwi_write_done", regs[4], 8'h5A);
    tick();
    tick();
    check("rwi_no_resp", bus.res_valid, 0);

    // Reset while in RESP with two entries queued.
    bus.in_data = 24'h0A0200;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 24'h000007;
    tick();
    bus.in_data = 24'h000008;
    tick();
    bus.in_valid = 1'b0;
    check("rresp_valid_before", bus.res_valid, 1);
    check("rresp_data_before", bus.res_data, 8'h3C);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("rresp_valid_after", bus.res_valid, 0);
    check("rresp_in_ready", bus.in_ready, 1);
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.DataIn != 8'h00 || bus.WEN) issued++;
    end
    check("rresp_no_issue", issued, 0);
    check("rresp_ins_count", bus.ins_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Command-side driver for the simple calculator. Accepts 24-bit instruction words over a valid/ready stream and buffers them in a small FIFO.
- Issues each instruction to the calculator's control ports (WEN/RW/RX/RY/DataIn/Sel/Ctrl) for one cycle.
- Optionally samples busY/Carry and returns them on a valid/ready result stream.
- Sits between a host/testbench command source and the calculator instance.

Parameters:
DEPTH, 4, instruction FIFO entries; power of two, >= 2
CNT_W, 8, width of the issued-instruction counter

Ports:
Clk  input  1  clock, all state on rising edge
Rst  input  1  synchronous active-high reset
in_data  input  24  instruction word
in_valid  input  1  instruction offered
in_ready  output  1  FIFO can accept (= !full)
WEN  output  1  calculator register-file write enable
RW  output  3  write register index
RX  output  3  X read index
RY  output  3  Y read index
DataIn  output  8  immediate to calculator
Sel  output  1  ALU X source select (1 = busX, 0 = DataIn)
Ctrl  output  4  ALU opcode
busY  input  8  calculator Y read bus (combinational from RY)
Carry  input  1  calculator carry
res_data  output  8  captured busY
res_carry  output  1  captured Carry
res_valid  output  1  result available
res_ready  input  1  result consumer ready
ins_count  output  CNT_W  instructions issued

Behaviour:
- Instruction word fields:
  - [23:20] ctrl, [19] sel, [18] wen, [17] rd (return result)
  - [16:14] rw, [13:11] rx, [10:8] ry, [7:0] imm
- Clock is Clk. Reset is Rst, synchronous and active-high: sampled only on the rising edge of Clk.
- Reset values:
  - FIFO empty, in_ready=1 (from the cycle after the reset edge).
  - State IDLE; all calculator-side outputs 0.
  - res_data=0, res_carry=0, res_valid=0, ins_count=0.
- FIFO:
  - Push when in_valid && in_ready. in_ready = !full, derived from registered occupancy.
  - When full, a push is refused even if a pop occurs the same cycle.
  - Simultaneous push/pop when not full keeps occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into instruction register, go ISSUE. Calculator outputs all 0 (WEN=0).
  - ISSUE: exactly one cycle. Drive ports from the instruction register: WEN=wen, RW=rw, RX=rx, RY=ry, DataIn=imm, Sel=sel, Ctrl=ctrl. ins_count increments (wraps at 2^CNT_W).
    - If rd=1: capture busY->res_data and Carry->res_carry at the ending edge, set res_valid, go RESP.
    - Else: go IDLE.
  - RESP: res_valid=1 and res_data/res_carry stable; calculator outputs 0. On res_ready, clear res_valid and go IDLE.
- Calculator outputs are decoded from the registered state and the instruction register: glitch-free, no combinational path from in_*.
- Latency:
  - Push at edge N -> earliest ISSUE cycle N+2 (FIFO write at N, pop/latch at N+1).
  - res_valid asserted from N+3.
  - Throughput: one non-rd instruction per 2 cycles.
- Same-instruction read and write (wen=1, rd=1): res_data is busY during the ISSUE cycle, i.e. the pre-write value of register ry, even when ry==rw.
- FIFO keeps accepting while in RESP. No pop occurs until RESP exits.
- Reset mid-operation:
  - Rst at the edge ending an ISSUE cycle with WEN=1: the calculator write still completes (the calculator is not reset). The sequencer discards any capture and returns to IDLE.
  - FIFO contents are lost.
- Ctrl values pass through unchecked.

Test Plan:
- Reset: hold Rst 2 cycles with in_valid=1 -> no push; after release in_ready=1, WEN=0, res_valid=0, ins_count=0.
- Write issue: push 0x244005 -> exactly one cycle with WEN=1, RW=1, Ctrl=2, Sel=0, DataIn=0x05, RX=RY=0; ins_count=1; no res_valid.
- Readback: push 0x0A0200 with bench model driving busY=0x3C, Carry=1 when RY=2 -> RY=2 and WEN=0 in ISSUE; res_valid high with res_data=0x3C, res_carry=1, held 5 cycles while res_ready=0; clears one cycle after res_ready=1.
- FIFO full/backpressure: res_ready=0, push 1 rd instruction then DEPTH more -> in_ready drops after DEPTH+1 accepted; the extra offer is refused and later accepted; issue order matches push order.
- Read-during-write hazard: wen=1, rd=1, rw=ry=3, reg3 previously 0x11 -> res_data=0x11, not the new value.
- Reset mid-RESP: Rst while res_valid=1 and FIFO holding 2 entries -> next cycle res_valid=0, in_ready=1, no further ISSUE cycles.
